// File: rtl/recv_capture_pkg.sv
// Shared types and constants for the receive-capture controller: FSM state
// encoding, counter width, trailer tag and trailer field positions.
package recv_capture_pkg;

   // Width of the word/drop counters and of cfg_words.
   localparam int CNT_W = 16;

   // Tag carried in the top 16 bits of every trailer word.
   localparam logic [15:0] MAGIC = 16'hC0DE;

   // Trailer word layout: {MAGIC, words, drops, aborted, 79'b0}.
   localparam int TRL_W         = 128;
   localparam int TRL_MAGIC_LSB = 112;
   localparam int TRL_WORDS_LSB = 96;
   localparam int TRL_DROPS_LSB = 80;
   localparam int TRL_ABORT_BIT = 79;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      CAPTURE = 2'd2,
      TRAILER = 2'd3
   } state_e;

endpackage

// File: rtl/recv_trailer_fmt.sv
// Combinational packing of the capture-statistics trailer word.
module recv_trailer_fmt
   import recv_capture_pkg::*;
(
   input  logic [CNT_W-1:0] words,
   input  logic [CNT_W-1:0] drops,
   input  logic             aborted,
   output logic [TRL_W-1:0] trailer
);

   // Place tag, counters and abort flag into their fixed fields; rest is zero.
   always_comb begin
      trailer                          = '0;
      trailer[TRL_MAGIC_LSB +: 16]     = MAGIC;
      trailer[TRL_WORDS_LSB +: CNT_W]  = words;
      trailer[TRL_DROPS_LSB +: CNT_W]  = drops;
      trailer[TRL_ABORT_BIT]           = aborted;
   end

endmodule

// File: rtl/recv_capture_ctrl.sv
// Acquisition sequencer: arms on start, gates ADC strobes into comm_recv for
// cfg_words packed words, then writes one statistics trailer to the FIFO.
// Optional level trigger on ad1 in ARM: define RECV_CAPTURE_CTRL_TRIG_EN.
module recv_capture_ctrl
   import recv_capture_pkg::*;
(
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] cfg_words,
   input  logic [7:0]       trig_level,
   input  logic [7:0]       ad1,
   input  logic             ad_valid_in,
   output logic             ad_valid_out,
   output logic             rx_rst,
   input  logic             rx_wr_en,
   input  logic [127:0]     rx_dout,
   output logic             rx_full,
   output logic             wr_en,
   output logic [127:0]     dout,
   input  logic             full,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cfg_words_q, cfg_words_d;
   logic [CNT_W-1:0] words_q, words_d;
   logic [CNT_W-1:0] drops_q, drops_d;
   logic             aborted_q, aborted_d;

   logic [CNT_W-1:0] words_inc;
   logic [TRL_W-1:0] trailer_word;

   // Ungated output values; forced to zero below while RST is high.
   logic             avo_c;
   logic             rx_rst_c;
   logic             rx_full_c;
   logic             wr_en_c;
   logic [127:0]     dout_c;
   logic             done_c;

`ifdef RECV_CAPTURE_CTRL_TRIG_EN
   logic             trig_hit;
   assign trig_hit = ad_valid_in && (ad1 >= trig_level);
`else
   // Trigger inputs have no function without the trigger feature.
   logic             unused_trig;
   assign unused_trig = ^{trig_level, ad1};
`endif

   assign words_inc = words_q + CNT_W'(1);

   recv_trailer_fmt u_trailer (
      .words   (words_q),
      .drops   (drops_q),
      .aborted (aborted_q),
      .trailer (trailer_word)
   );

   // State and statistics registers with synchronous reset.
   always_ff @(posedge CLK) begin
      // NOTE: state is updated only with non-blocking assignments so every
      // register samples the pre-edge values computed by the combinational block.
      if (RST) begin
         state_q     <= IDLE;
         cfg_words_q <= '0;
         words_q     <= '0;
         drops_q     <= '0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cfg_words_q <= cfg_words_d;
         words_q     <= words_d;
         drops_q     <= drops_d;
         aborted_q   <= aborted_d;
      end
   end

   // Next-state, counter updates and per-state output decode.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path can
      // leave one unassigned and infer a latch.
      state_d     = state_q;
      cfg_words_d = cfg_words_q;
      words_d     = words_q;
      drops_d     = drops_q;
      aborted_d   = aborted_q;
      avo_c       = 1'b0;
      rx_rst_c    = 1'b0;
      rx_full_c   = 1'b0;
      wr_en_c     = 1'b0;
      dout_c      = '0;
      done_c      = 1'b0;

      unique case (state_q)
         IDLE: begin
            // abort is ignored here; start always wins.
            if (start) begin
               cfg_words_d = cfg_words;
               words_d     = '0;
               drops_d     = '0;
               aborted_d   = 1'b0;
               rx_rst_c    = 1'b1;
               state_d     = ARM;
            end
         end

         ARM: begin
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = TRAILER;
            end else if (cfg_words_q == '0) begin
               state_d = TRAILER;
            end else begin
`ifdef RECV_CAPTURE_CTRL_TRIG_EN
               // The triggering sample is the first one handed to comm_recv.
               if (trig_hit) begin
                  avo_c   = ~full;
                  state_d = CAPTURE;
               end
`else
               state_d = CAPTURE;
`endif
            end
         end

         CAPTURE: begin
            avo_c     = ad_valid_in & ~full;
            rx_full_c = full;
            wr_en_c   = rx_wr_en;
            dout_c    = rx_dout;
            if (ad_valid_in && full && (drops_q != '1)) begin
               drops_d = drops_q + CNT_W'(1);
            end
            if (rx_wr_en) begin
               words_d = words_inc;
            end
            // A write coincident with abort is still forwarded and counted.
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = TRAILER;
            end else if (rx_wr_en && (words_inc == cfg_words_q)) begin
               state_d = TRAILER;
            end
         end

         TRAILER: begin
            // comm_recv writes are blocked; its partial word is discarded.
            if (!full) begin
               wr_en_c = 1'b1;
               dout_c  = trailer_word;
               done_c  = 1'b1;
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Outputs are held at zero for the whole reset cycle.
   always_comb begin
      ad_valid_out = avo_c & ~RST;
      rx_rst       = rx_rst_c & ~RST;
      rx_full      = rx_full_c & ~RST;
      wr_en        = wr_en_c & ~RST;
      dout         = RST ? '0 : dout_c;
      done         = done_c & ~RST;
      busy         = (state_q != IDLE) & ~RST;
   end

endmodule

// File: tb/tb_recv_capture_ctrl.sv
// Randomized self-checking bench for recv_capture_ctrl. Expected behaviour is
// derived from the phase the bench itself drives (start, arm, capture,
// trailer) and from running word/drop/abort tallies kept in plain integers.
module tb_recv_capture_ctrl;

   logic         CLK;
   logic         RST;
   logic         start;
   logic         abort;
   logic [15:0]  cfg_words;
   logic [7:0]   trig_level;
   logic [7:0]   ad1;
   logic         ad_valid_in;
   logic         ad_valid_out;
   logic         rx_rst;
   logic         rx_wr_en;
   logic [127:0] rx_dout;
   logic         rx_full;
   logic         wr_en;
   logic [127:0] dout;
   logic         full;
   logic         busy;
   logic         done;

   int n_vec = 0;
   int n_err = 0;

   // Reference tallies for the capture in progress.
   int m_words;
   int m_drops;
   bit m_ab;
   bit first_trig = 1'b1;

   recv_capture_ctrl dut (
      .CLK          (CLK),
      .RST          (RST),
      .start        (start),
      .abort        (abort),
      .cfg_words    (cfg_words),
      .trig_level   (trig_level),
      .ad1          (ad1),
      .ad_valid_in  (ad_valid_in),
      .ad_valid_out (ad_valid_out),
      .rx_rst       (rx_rst),
      .rx_wr_en     (rx_wr_en),
      .rx_dout      (rx_dout),
      .rx_full      (rx_full),
      .wr_en        (wr_en),
      .dout         (dout),
      .full         (full),
      .busy         (busy),
      .done         (done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Flags in order {ad_valid_out, rx_rst, wr_en, busy, done}.
   task automatic chk_flags(input string tag, input logic [4:0] exp);
      check(tag, {ad_valid_out, rx_rst, wr_en, busy, done}, exp);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [127:0] exp_trailer(input int w, input int d, input bit a);
      logic [127:0] t;
      t          = '0;
      t[127:112] = 16'hC0DE;
      t[111:96]  = w[15:0];
      t[95:80]   = d[15:0];
      t[79]      = a;
      return t;
   endfunction

   task automatic step();
      @(negedge CLK);
   endtask

   task automatic quiet();
      start       = 1'b0;
      abort       = 1'b0;
      ad_valid_in = 1'b0;
      rx_wr_en    = 1'b0;
      full        = 1'b0;
      rx_dout     = rnd128();
      ad1         = 8'($urandom());
      cfg_words   = 16'($urandom());
   endtask

   task automatic do_start(input int n);
      quiet();
      start       = 1'b1;
      cfg_words   = n[15:0];
      abort       = 1'($urandom_range(0, 1));
      ad_valid_in = 1'($urandom_range(0, 1));
      rx_wr_en    = 1'($urandom_range(0, 1));
      #1 chk_flags("start", 5'b01000);
      step();
      m_words = 0;
      m_drops = 0;
      m_ab    = 1'b0;
   endtask

   task automatic do_arm(input int n, input bit abort_arm, output bit to_capture);
      to_capture = 1'b0;
`ifdef RECV_CAPTURE_CTRL_TRIG_EN
      begin
         bit use_seq;
         bit hit;
         bit fwd;
         use_seq    = first_trig && !abort_arm && (n != 0);
         trig_level = use_seq ? 8'h80 : 8'($urandom());
         for (int c = 0; c < 64; c++) begin
            quiet();
            abort    = abort_arm;
            rx_wr_en = 1'($urandom_range(0, 1));
            if (use_seq) begin
               ad_valid_in = 1'b1;
               case (c)
                  0:       ad1 = 8'h10;
                  1:       ad1 = 8'h7F;
                  default: ad1 = 8'h80;
               endcase
            end else if (c >= 6) begin
               ad_valid_in = 1'b1;
               ad1         = trig_level;
            end else begin
               ad_valid_in = 1'($urandom_range(0, 1));
            end
            hit = ad_valid_in && (ad1 >= trig_level);
            fwd = !abort_arm && (n != 0) && hit;
            #1 chk_flags("arm_trig", {fwd, 4'b0010});
            step();
            if (abort_arm) begin
               m_ab = 1'b1;
               return;
            end
            if (n == 0) return;
            if (hit) begin
               first_trig = first_trig && !use_seq;
               to_capture = 1'b1;
               return;
            end
         end
         check("arm_timeout", 1, 0);
      end
`else
      quiet();
      trig_level  = 8'($urandom());
      abort       = abort_arm;
      ad_valid_in = 1'($urandom_range(0, 1));
      rx_wr_en    = 1'($urandom_range(0, 1));
      full        = 1'($urandom_range(0, 1));
      #1 chk_flags("arm", 5'b00010);
      step();
      if (abort_arm) m_ab = 1'b1;
      else           to_capture = (n != 0);
`endif
   endtask

   // mode 0: random traffic; 1: 5 cycles of full with valid first; 2: clean stream.
   task automatic do_capture(input int n, input int abort_at, input int mode);
      bit v, f, w, ab, fin;
      int cyc;
      fin = 1'b0;
      cyc = 0;
      while (!fin) begin
         quiet();
         if (mode == 2) begin
            v = 1'b1; f = 1'b0; w = 1'b1;
         end else if (mode == 1 && cyc < 5) begin
            v = 1'b1; f = 1'b1; w = 1'b0;
         end else begin
            v = 1'($urandom_range(0, 1));
            f = (mode == 0) && ($urandom_range(0, 3) == 0);
            w = ($urandom_range(0, 2) != 0);
         end
         ab          = (abort_at >= 0) && (m_words >= abort_at);
         ad_valid_in = v;
         full        = f;
         rx_wr_en    = w;
         abort       = ab;
         start       = ($urandom_range(0, 7) == 0);
         #1 chk_flags("cap", {v & ~f, 1'b0, w, 1'b1, 1'b0});
         check("cap_rx_full", rx_full, f);
         if (w) check("cap_dout", dout, rx_dout);
         step();
         if (v && f && m_drops != 16'hFFFF) m_drops++;
         if (w) m_words++;
         if (ab) begin
            m_ab = 1'b1;
            fin  = 1'b1;
         end else if (w && m_words == n) begin
            fin = 1'b1;
         end
         cyc++;
         if (cyc > 5000) begin
            check("cap_timeout", 1, 0);
            fin = 1'b1;
         end
      end
   endtask

   task automatic do_trailer(input int stall);
      for (int k = 0; k < stall; k++) begin
         quiet();
         full        = 1'b1;
         rx_wr_en    = 1'b1;
         ad_valid_in = 1'b1;
         start       = 1'($urandom_range(0, 1));
         #1 chk_flags("trl_stall", 5'b00010);
         step();
      end
      quiet();
      rx_wr_en    = 1'($urandom_range(0, 1));
      ad_valid_in = 1'b1;
      #1 chk_flags("trl_write", 5'b00111);
      check("trl_dout", dout, exp_trailer(m_words, m_drops, m_ab));
      step();
      quiet();
      #1 chk_flags("post_idle", 5'b00000);
      step();
   endtask

   // abort_at: -2 none, -1 abort in ARM, >=0 abort once that many words are counted.
   task automatic run(input int n, input int abort_at, input int mode, input int stall);
      bit go;
      do_start(n);
      do_arm(n, abort_at == -1, go);
      if (go) do_capture(n, abort_at, mode);
      do_trailer(stall);
   endtask

   task automatic run_reset_mid();
      bit go;
      do_start(50);
      do_arm(50, 1'b0, go);
      for (int i = 0; i < 3; i++) begin
         quiet();
         ad_valid_in = 1'b1;
         rx_wr_en    = 1'b1;
         #1 chk_flags("rst_cap", 5'b10110);
         step();
      end
      quiet();
      RST         = 1'b1;
      ad_valid_in = 1'b1;
      rx_wr_en    = 1'b1;
      #1 chk_flags("rst_during", 5'b00000);
      check("rst_dout", dout, '0);
      check("rst_rx_full", rx_full, 1'b0);
      step();
      RST = 1'b0;
      for (int i = 0; i < 4; i++) begin
         quiet();
         ad_valid_in = 1'b1;
         rx_wr_en    = 1'b1;
         #1 chk_flags("rst_after", 5'b00000);
         step();
      end
   endtask

   initial begin
      RST        = 1'b1;
      trig_level = 8'h00;
      quiet();
      @(negedge CLK);
      step();
      #1 chk_flags("reset", 5'b00000);
      check("reset_dout", dout, '0);
      step();
      RST = 1'b0;

      run(3, -2, 2, 0);      // basic
      run(2, -2, 1, 0);      // backpressure: drops=5
      run(0, -2, 2, 0);      // zero length
      run(100, 4, 2, 0);     // abort after 4 words
      run(5, -2, 2, 3);      // trailer stalled 3 cycles
      run_reset_mid();
      run(7, -1, 0, 0);      // abort while armed
      run(0, -1, 2, 1);      // abort and zero length together

      for (int r = 0; r < 40; r++) begin
         int n, sel, ab_at;
         n   = $urandom_range(0, 12);
         sel = $urandom_range(0, 3);
         if (sel == 0)      ab_at = -1;
         else if (sel == 1) ab_at = $urandom_range(0, 12);
         else               ab_at = -2;
         run(n, ab_at, 0, $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
